// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory,
// buffers {instr, pc} responses in a DEPTH-entry circular buffer for decode,
// predecodes unconditional B words to steer fetch early, and flushes on
// an external redirect.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   im_req, im_addr    fetch request and byte address to instruction memory
//   im_data            instruction word, valid one cycle after im_req
//   redirect(_pc)      taken branch/jump from decode/execute and its target
//   id_valid/id_ready  head-entry handshake with decode
//   id_instr, id_pc    head instruction and its address (NOP/0 when empty)
//   count              number of occupied entries
module fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     im_req,
  output logic [ADDR_W-1:0]        im_addr,
  input  logic [DATA_W-1:0]        im_data,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_W-1:0]        id_instr,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] NOP   = DATA_W'(32'hC800_0000);
  localparam logic [6:0]        OP_B  = 7'b1100000;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];

  logic [CNT_W:0]    w_occupied;
  logic              w_req;
  logic              w_valid;
  logic              w_deq;
  logic              w_enq;
  logic              w_is_b;
  logic [ADDR_W-1:0] w_b_off;
  logic [ADDR_W-1:0] w_b_target;
  logic [ADDR_W-1:0] w_pc_next;

  // Entries already held or promised by an outstanding request.
  assign w_occupied = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_req      = !reset && !redirect && (w_occupied < (CNT_W+1)'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_deq      = w_valid && id_ready;
  // A response arriving in a redirect cycle belongs to the flushed path.
  assign w_enq      = r_inflight && !redirect;
  assign w_is_b     = w_enq && (im_data[31:25] == OP_B);
  assign w_b_off    = ADDR_W'($signed(im_data[15:0]));
  assign w_b_target = (r_inflight_pc + w_b_off) & ALIGN;

  // Fetch PC priority: redirect, then B predecode, then sequential advance.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect) begin
      w_pc_next = redirect_pc & ALIGN;
    end else if (w_is_b) begin
      w_pc_next = w_b_target;
    end else if (w_req) begin
      w_pc_next = r_pc + ADDR_W'(4);
    end
  end

  // Control state: fetch PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_pc <= w_pc_next;
      // A B word kills the request issued alongside it (wrong path).
      r_inflight <= w_req && !w_is_b;
      if (w_req) begin
        r_inflight_pc <= r_pc;
      end
      if (redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_deq) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_instr[r_wptr] <= im_data;
      r_mem_pc[r_wptr]    <= r_inflight_pc;
    end
  end

  assign im_req   = w_req;
  assign im_addr  = r_pc;
  assign id_valid = w_valid;
  assign id_instr = w_valid ? r_mem_instr[r_rptr] : NOP;
  assign id_pc    = w_valid ? r_mem_pc[r_rptr] : '0;
  assign count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset state, streaming fetch, back-pressure
// saturation and drain order, B predecode, redirect flush, redirect-vs-B
// priority and mid-operation reset.
module tb_fetch_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;
  int b_mode   = 0;

  fetch_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: plain words tagged with their address, plus optional B words.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
    if (mode == 1 && a == 32'h20) return 32'hC000_FFF8;
    if (mode == 2 && a == 32'h60) return 32'hC000_0020;
    return {8'h10, a[23:0]};
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (im_req) im_data <= mem_word(im_addr, b_mode);
    else        im_data <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b1;
    im_data     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_im_req",   64'(im_req),   64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_id_instr", 64'(id_instr), 64'hC800_0000);
    chk("rst_id_pc",    64'(id_pc),    64'd0);

    // Streaming fetch after release
    reset = 1'b0;
    #1;
    chk("rel_im_req",  64'(im_req),  64'd1);
    chk("rel_im_addr", 64'(im_addr), 64'h0);
    tick();
    chk("s1_im_addr",  64'(im_addr),  64'h4);
    chk("s1_id_valid", 64'(id_valid), 64'd0);
    tick();
    chk("s2_id_valid", 64'(id_valid), 64'd1);
    chk("s2_id_pc",    64'(id_pc),    64'h0);
    chk("s2_id_instr", 64'(id_instr), 64'h1000_0000);
    chk("s2_im_addr",  64'(im_addr),  64'h8);
    tick();
    chk("s3_id_pc", 64'(id_pc), 64'h4);
    tick();
    chk("s4_id_pc", 64'(id_pc), 64'h8);

    // Back-pressure: saturate at DEPTH, then drain in order
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("full_count",    64'(count),    64'd4);
    chk("full_im_req",   64'(im_req),   64'd0);
    chk("full_id_valid", 64'(id_valid), 64'd1);
    id_ready = 1'b1;
    #1;
    chk("drain0_pc",    64'(id_pc),    64'h0);
    chk("drain0_instr", 64'(id_instr), 64'h1000_0000);
    tick();
    chk("drain1_pc", 64'(id_pc), 64'h4);
    tick();
    chk("drain2_pc", 64'(id_pc), 64'h8);
    tick();
    chk("drain3_pc",    64'(id_pc),    64'hC);
    chk("drain3_instr", 64'(id_instr), 64'h1000_000C);

    // B predecode at 0x20 -> 0x18; the 0x24 response is dropped
    b_mode   = 1;
    id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && im_addr != 32'h24; i++) tick();
    chk("b_wait_addr", 64'(im_addr), 64'h24);
    tick();
    chk("b_im_addr",  64'(im_addr),  64'h18);
    chk("b_id_pc",    64'(id_pc),    64'h20);
    chk("b_id_instr", 64'(id_instr), 64'hC000_FFF8);
    tick();
    chk("b_bubble", 64'(id_valid), 64'd0);
    tick();
    chk("b_tgt_pc",    64'(id_pc),    64'h18);
    chk("b_tgt_instr", 64'(id_instr), 64'h1000_0018);
    b_mode = 0;

    // Redirect with 3 entries queued and one in flight
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && count != 3'd3; i++) tick();
    chk("rd_wait_cnt", 64'(count), 64'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("rd_im_req_low", 64'(im_req), 64'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_count",    64'(count),    64'd0);
    chk("rd_id_valid", 64'(id_valid), 64'd0);
    chk("rd_id_instr", 64'(id_instr), 64'hC800_0000);
    chk("rd_im_addr",  64'(im_addr),  64'h100);
    chk("rd_im_req",   64'(im_req),   64'd1);
    tick();
    chk("rd_no_stale", 64'(count), 64'd0);
    tick();
    chk("rd_new_pc",    64'(id_pc),    64'h100);
    chk("rd_new_instr", 64'(id_instr), 64'h1000_0100);

    // Redirect to 0x40 beats B predecode to 0x80 on the same edge
    b_mode   = 2;
    id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && im_addr != 32'h64; i++) tick();
    chk("pri_wait_addr", 64'(im_addr), 64'h64);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    chk("pri_im_addr", 64'(im_addr), 64'h40);
    chk("pri_count",   64'(count),   64'd0);
    b_mode = 0;

    // Reset mid-operation with queued entries and a response in flight
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && count != 3'd3; i++) tick();
    chk("mr_wait_cnt", 64'(count), 64'd3);
    reset = 1'b1;
    #1;
    chk("mr_count",    64'(count),    64'd0);
    chk("mr_id_valid", 64'(id_valid), 64'd0);
    chk("mr_id_instr", 64'(id_instr), 64'hC800_0000);
    chk("mr_id_pc",    64'(id_pc),    64'd0);
    chk("mr_im_req",   64'(im_req),   64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mr_rel_addr",  64'(im_addr), 64'h0);
    chk("mr_rel_req",   64'(im_req),  64'd1);
    chk("mr_rel_count", 64'(count),   64'd0);
    tick();
    tick();
    chk("mr_first_pc",    64'(id_pc),    64'h0);
    chk("mr_first_count", 64'(count),    64'd1);
    chk("mr_first_instr", 64'(id_instr), 64'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
